tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Multi-channel programmable tick generator; the parametrised successor to the fixed 1 kHz divider.
- NUM_CH independent channels share one system clock. Each channel emits a one-cycle tick every DIV cycles.
- Divisors are set at runtime through a shadow register. A new divisor is applied glitch-free at the channel's next terminal count.
- Feeds the FND scan, DHT11 sampling and UART timeout logic from a single instance.

Parameters:
- NUM_CH, 4, number of independent tick channels (>=2).
- DIV_W, 27, divisor and counter width in bits.
- DEFAULT_DIV, 100000, divisor loaded into every channel at reset (1 kHz at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_en  input  NUM_CH  per-channel enable.
- i_restart  input  NUM_CH  per-channel synchronous phase restart, one-cycle pulse.
- i_div_wr  input  1  divisor write strobe.
- i_div_sel  input  $clog2(NUM_CH)  channel targeted by the write.
- i_div_data  input  DIV_W  new divisor value.
- o_tick  output  NUM_CH  registered one-cycle tick per channel.
- o_div_pend  output  NUM_CH  written divisor not yet applied.
- o_sq  output  NUM_CH  50% square wave; only present with TICKGEN_SQ_EN.

Behaviour:
- Reset (reset=0, asynchronous), per channel:
  - cnt=0.
  - active_div = shadow_div = DEFAULT_DIV.
  - o_div_pend=0, o_tick=0, o_sq=0.
- Effective divisor: eff = (active_div==0) ? 1 : active_div. Zero is never a divide-by-zero.
- Counting, channel enabled, no restart:
  - cnt increments each clk.
  - At cnt==eff-1: cnt<=0 and o_tick<=1 (registered). o_tick is high for the cycle after the terminal count.
  - Every other cycle o_tick<=0.
- Tick period is exactly eff cycles. eff=1 gives o_tick high continuously.
- First tick after enable rise or restart appears eff cycles later (tick on the eff-th rising edge).
- Disabled (i_en[k]=0): cnt<=0 and o_tick<=0. A pending divisor is applied immediately (active<=shadow, pend<=0).
- Restart (i_restart[k]=1): cnt<=0 and o_tick<=0 that cycle. A pending divisor is applied. Restart has priority over the terminal count.
- Divisor write (i_div_wr=1):
  - shadow_div[i_div_sel]<=i_div_data and o_div_pend[sel]<=1.
  - A later write while pending overwrites the shadow; last write wins.
- Apply at terminal count: if pend, active<=shadow and pend<=0. The new period starts with the next count sequence.
- Write coinciding with that channel's terminal count, disable or restart: i_div_data is applied directly (bypass). Pend stays 0.
- i_div_sel >= NUM_CH: write ignored.
- All channels are fully independent; writes to one channel never disturb another's phase.
- Arithmetic: cnt is DIV_W bits unsigned. Comparison is against eff-1 only; no wrap past eff-1.

Optional Feature:
- Macro: TICKGEN_SQ_EN.
- Defined:
  - o_sq[k] toggles at cnt==0 and at cnt==eff/2 (integer division).
  - Gives 50% duty for even eff; for odd eff, high lasts floor(eff/2) cycles.
  - For eff=1, o_sq stays 0.
  - Forced 0 when disabled or restarted.
- Undefined: o_sq port and its logic are absent. Tick behaviour is identical either way.

Test Plan:
- Reset release, all en=1, DEFAULT_DIV=10 (bench override) -> first o_tick at cycle 10, then every 10 cycles, pulse width 1; o_div_pend=0.
- ch0 div write 4 at cnt=2 of a 10-cycle period -> pend=1 until terminal; current period completes at 10 cycles, then ticks every 4; pend clears at the terminal edge.
- Write div=0 to ch1, then div=1 to ch2 -> both ticks high every cycle; no X, no lockup.
- ch3 i_restart pulse mid-count (cnt=6, div=10) -> no tick that cycle; next tick exactly 10 cycles after restart; ch0–ch2 phases unchanged.
- Write to ch0 on the exact terminal-count cycle, data=7 -> next period is 7 cycles, pend never asserts. Drop i_en mid-period -> o_tick=0 and cnt=0 within 1 cycle.
- Assert reset low asynchronously mid-period (between clk edges) -> o_tick and o_div_pend 0 immediately, divisors back to DEFAULT_DIV. With TICKGEN_SQ_EN and div=8, o_sq is 4 high / 4 low.

Source files
------------

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel programmable tick generator.
// Each of NUM_CH channels emits a registered one-cycle tick every eff cycles,
// where eff = active_div, or 1 when active_div is 0. Divisors are written into
// a per-channel shadow register. The shadow value becomes active at the next
// terminal count, disable or restart, so a period change never glitches.
// Optional feature: define TICKGEN_SQ_EN to add the o_sq 50% square-wave outputs.
module tick_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         i_en,
    input  logic [NUM_CH-1:0]         i_restart,
    input  logic                      i_div_wr,
    input  logic [$clog2(NUM_CH)-1:0] i_div_sel,
    input  logic [DIV_W-1:0]          i_div_data,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_div_pend
`ifdef TICKGEN_SQ_EN
    ,
    output logic [NUM_CH-1:0]         o_sq
`endif
);

    localparam int               SEL_W = $clog2(NUM_CH);
    localparam logic [DIV_W-1:0] DEF   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [DIV_W-1:0] cnt_reg    [NUM_CH];
    logic [DIV_W-1:0] cnt_next   [NUM_CH];
    logic [DIV_W-1:0] active_reg [NUM_CH];
    logic [DIV_W-1:0] active_next[NUM_CH];
    logic [DIV_W-1:0] shadow_reg [NUM_CH];
    logic [DIV_W-1:0] shadow_next[NUM_CH];
    logic             tick_reg   [NUM_CH];
    logic             tick_next  [NUM_CH];
    logic             pend_reg   [NUM_CH];
    logic             pend_next  [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] eff;
            logic [DIV_W-1:0] last;
            logic             wr_hit;
            logic             clear;
            logic             term;

            // A zero divisor behaves as divide-by-one so the counter can never lock up.
            assign eff = (active_reg[gi] == '0) ? ONE : active_reg[gi];
            assign last = eff - ONE;
            // Because gi is always below NUM_CH, a select value of NUM_CH or more matches no channel.
            assign wr_hit = i_div_wr && (i_div_sel == SEL_W'(gi));
            assign clear = !i_en[gi] || i_restart[gi];
            assign term = (cnt_reg[gi] == last);

            // Next-state logic: clear (disable/restart) beats terminal count; both are safe apply points
            always_comb begin
                cnt_next[gi]    = cnt_reg[gi];
                active_next[gi] = active_reg[gi];
                shadow_next[gi] = shadow_reg[gi];
                pend_next[gi]   = pend_reg[gi];
                tick_next[gi]   = 1'b0;
                if (clear || term) begin
                    cnt_next[gi]  = '0;
                    tick_next[gi] = !clear;
                    if (wr_hit) begin
                        // A write that lands on an apply point bypasses the shadow stage.
                        active_next[gi] = i_div_data;
                        shadow_next[gi] = i_div_data;
                        pend_next[gi]   = 1'b0;
                    end else if (pend_reg[gi]) begin
                        active_next[gi] = shadow_reg[gi];
                        pend_next[gi]   = 1'b0;
                    end
                end else begin
                    cnt_next[gi] = cnt_reg[gi] + ONE;
                    if (wr_hit) begin
                        shadow_next[gi] = i_div_data;
                        pend_next[gi]   = 1'b1;
                    end
                end
            end

            // Channel state registers with asynchronous active-low reset
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi]    <= '0;
                    active_reg[gi] <= DEF;
                    shadow_reg[gi] <= DEF;
                    pend_reg[gi]   <= 1'b0;
                    tick_reg[gi]   <= 1'b0;
                end else begin
                    cnt_reg[gi]    <= cnt_next[gi];
                    active_reg[gi] <= active_next[gi];
                    shadow_reg[gi] <= shadow_next[gi];
                    pend_reg[gi]   <= pend_next[gi];
                    tick_reg[gi]   <= tick_next[gi];
                end
            end

            assign o_tick[gi]     = tick_reg[gi];
            assign o_div_pend[gi] = pend_reg[gi];

`ifdef TICKGEN_SQ_EN
            logic [DIV_W-1:0] half;
            logic             sq_reg;
            logic             sq_next;

            assign half = eff >> 1;

            // Square wave: rises at cnt==0 and falls at cnt==eff/2. With eff==1 both
            // points coincide, so the output stays low.
            always_comb begin
                sq_next = sq_reg;
                if (clear || (eff == ONE)) begin
                    sq_next = 1'b0;
                end else if (cnt_reg[gi] == '0) begin
                    sq_next = 1'b1;
                end else if (cnt_reg[gi] == half) begin
                    sq_next = 1'b0;
                end
            end

            // Square-wave register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sq_reg <= 1'b0;
                end else begin
                    sq_reg <= sq_next;
                end
            end

            assign o_sq[gi] = sq_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed bench for tick_gen_multi (NUM_CH=4, DEFAULT_DIV=10).
// The bench model is time-based. For each channel it keeps the edge number at
// which the current count sequence started and the period in force. A tick is
// due when exactly eff edges have passed since that start.
module tb_tick_gen_multi;

    localparam int NCH   = 4;
    localparam int DW    = 27;
    localparam int DEFDV = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NCH-1:0]  i_en = '1;
    logic [NCH-1:0]  i_restart = '0;
    logic            i_div_wr = 1'b0;
    logic [1:0]      i_div_sel = '0;
    logic [DW-1:0]   i_div_data = '0;
    logic [NCH-1:0]  o_tick;
    logic [NCH-1:0]  o_div_pend;
`ifdef TICKGEN_SQ_EN
    logic [NCH-1:0]  o_sq;
`endif

    int errors = 0;
    int checks = 0;

    tick_gen_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEFDV)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .i_restart  (i_restart),
        .i_div_wr   (i_div_wr),
        .i_div_sel  (i_div_sel),
        .i_div_data (i_div_data),
        .o_tick     (o_tick),
        .o_div_pend (o_div_pend)
`ifdef TICKGEN_SQ_EN
        ,
        .o_sq       (o_sq)
`endif
    );

    always #5 clk = ~clk;

    // Inputs as seen by the DUT at each rising edge
    logic           s_rst = 1'b0;
    logic [NCH-1:0] s_en, s_rs;
    logic           s_wr;
    logic [1:0]     s_sel;
    logic [DW-1:0]  s_data;
    always @(posedge clk) begin
        s_rst  <= reset;
        s_en   <= i_en;
        s_rs   <= i_restart;
        s_wr   <= i_div_wr;
        s_sel  <= i_div_sel;
        s_data <= i_div_data;
    end

    // Model state
    int             n = 0;
    int             start_e [NCH];
    longint         per     [NCH];
    longint         shadow  [NCH];
    bit [NCH-1:0]   m_tick, m_pend, m_sq;

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < NCH; k++) begin
            start_e[k] = 0;
            per[k]     = DEFDV;
            shadow[k]  = DEFDV;
        end
        m_tick = '0;
        m_pend = '0;
        m_sq   = '0;
    endtask

    task automatic model_step();
        n++;
        for (int k = 0; k < NCH; k++) begin
            longint eff = (per[k] == 0) ? 1 : per[k];
            bit wr  = s_wr && (int'(s_sel) == k);
            bit clr = !s_en[k] || s_rs[k];
            if (clr || (longint'(n - start_e[k]) == eff)) begin
                m_tick[k]  = !clr;
                m_sq[k]    = 1'b0;
                start_e[k] = n;
                if (wr) begin
                    per[k] = s_data; shadow[k] = s_data; m_pend[k] = 1'b0;
                end else if (m_pend[k]) begin
                    per[k] = shadow[k]; m_pend[k] = 1'b0;
                end
            end else begin
                longint ph = n - start_e[k];
                m_tick[k] = 1'b0;
                m_sq[k]   = (eff > 1) && (ph >= 1) && (ph <= eff / 2);
                if (wr) begin
                    shadow[k] = s_data; m_pend[k] = 1'b1;
                end
            end
        end
    endtask

    // Compare process: advance model per edge, then check every output
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            else if (s_rst) model_step();
            checks++;
            if (o_tick !== m_tick) begin
                errors++;
                $display("FAIL tick n=%0d got=%b want=%b", n, o_tick, m_tick);
            end
            checks++;
            if (o_div_pend !== m_pend) begin
                errors++;
                $display("FAIL pend n=%0d got=%b want=%b", n, o_div_pend, m_pend);
            end
`ifdef TICKGEN_SQ_EN
            checks++;
            if (o_sq !== m_sq) begin
                errors++;
                $display("FAIL sq n=%0d got=%b want=%b", n, o_sq, m_sq);
            end
`endif
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%0h want=%0h", name, n, act, exp);
        end else begin
            $display("ok   %s n=%0d value=%0h", name, n, act);
        end
    endtask

    // Advance to 1 time unit after the falling edge that follows rising edge N
    task automatic go(input int target);
        int guard = 0;
        while (n < target) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL go_timeout n=%0d want=%0d", n, target);
                errors++;
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic wr(input int ch, input int data);
        i_div_wr   = 1'b1;
        i_div_sel  = 2'(ch);
        i_div_data = DW'(data);
    endtask

    initial begin
        #1;
        lit("reset_tick", 32'(o_tick), 32'h0);
        lit("reset_pend", 32'(o_div_pend), 32'h0);
        @(negedge clk); @(negedge clk); #2;
        reset = 1'b1;

        // Default divisor of 10: first tick on edge 10, one-cycle pulse
        go(9);  lit("first_tick_pre", 32'(o_tick), 32'h0);
        go(10); lit("first_tick_all", 32'(o_tick), 32'hF);
        lit("first_pend", 32'(o_div_pend), 32'h0);
        go(11); lit("pulse_width", 32'(o_tick), 32'h0);

        // ch0 divisor 4 written at cnt=2, applied at terminal of edge 20
        go(12); wr(0, 4);
        go(13); i_div_wr = 1'b0; lit("pend_set", 32'(o_div_pend), 32'h1);
        go(19); lit("pend_hold", 32'(o_div_pend), 32'h1);
        go(20); lit("old_period_tick", 32'(o_tick[0]), 32'h1);
        lit("pend_clear", 32'(o_div_pend), 32'h0);
        go(23); lit("new_period_pre", 32'(o_tick[0]), 32'h0);
        go(24); lit("new_period_tick", 32'(o_tick[0]), 32'h1);

        // ch1 divisor 0 and ch2 divisor 1: tick every cycle after edge 30
        go(25); wr(1, 0);
        go(26); wr(2, 1);
        go(27); i_div_wr = 1'b0;
        go(32); lit("div0_div1_a", 32'(o_tick[2:1]), 32'h3);
        go(33); lit("div0_div1_b", 32'(o_tick[2:1]), 32'h3);

        // ch3 restart at cnt=6; next tick 10 edges later
        go(36); i_restart = 4'b1000;
        go(37); i_restart = '0; lit("restart_no_tick", 32'(o_tick[3]), 32'h0);
        go(40); lit("restart_old_phase", 32'(o_tick[3]), 32'h0);
        lit("ch0_phase_kept", 32'(o_tick[0]), 32'h1);
        go(47); lit("restart_tick", 32'(o_tick[3]), 32'h1);

        // Write on ch0 terminal-count cycle: bypass, no pend
        go(51); wr(0, 7);
        go(52); i_div_wr = 1'b0;
        lit("bypass_tick", 32'(o_tick[0]), 32'h1);
        lit("bypass_no_pend", 32'(o_div_pend[0]), 32'h0);
        go(58); lit("bypass_pre", 32'(o_tick[0]), 32'h0);
        go(59); lit("bypass_period7", 32'(o_tick[0]), 32'h1);

        // Drop ch3 enable for one cycle: counter restarts from zero
        go(60); i_en = 4'b0111;
        go(61); i_en = 4'b1111; lit("disable_tick", 32'(o_tick[3]), 32'h0);
        go(70); lit("reenable_pre", 32'(o_tick[3]), 32'h0);
        go(71); lit("reenable_tick", 32'(o_tick[3]), 32'h1);

        // ch1 gets divisor 8 (applied at once since eff was 1)
        go(72); wr(1, 8);
        go(73); i_div_wr = 1'b0;
`ifdef TICKGEN_SQ_EN
        go(75); lit("sq_high", 32'(o_sq[1]), 32'h1);
        go(79); lit("sq_low", 32'(o_sq[1]), 32'h0);
        lit("sq_eff1_low", 32'(o_sq[2]), 32'h0);
`endif
        go(81); lit("div8_tick", 32'(o_tick[1]), 32'h1);

        // Asynchronous reset mid-cycle with a pending write outstanding
        go(84); wr(0, 3);
        go(85); i_div_wr = 1'b0;
        lit("pre_reset_pend", 32'(o_div_pend), 32'h1);
        lit("pre_reset_tick2", 32'(o_tick[2]), 32'h1);
        #1 reset = 1'b0;
        #1;
        lit("async_tick", 32'(o_tick), 32'h0);
        lit("async_pend", 32'(o_div_pend), 32'h0);
        @(negedge clk); #2;
        reset = 1'b1;
        go(9);  lit("post_reset_pre", 32'(o_tick), 32'h0);
        go(10); lit("post_reset_default", 32'(o_tick), 32'hF);
        go(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog n=%0d", n);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
